// File: rtl/puf_pkg.sv
// Shared PUF controller types: scheduler state encoding and sizing helpers.
package puf_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT,
        OUTPUT
    } sched_state_t;

    // Index counters need at least one bit even for single-entry batches.
    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/puf_watchdog.sv
// Per-evaluation watchdog: counts enabled cycles, flags expiry at TIMEOUT_CYCLES-1.
module puf_watchdog #(
    parameter int TIMEOUT_BITS   = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMEOUT_BITS-1:0] count;

    assign expired = (count == TIMEOUT_BITS'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + TIMEOUT_BITS'(1);
        end
    end

endmodule

// File: rtl/puf_challenge_scheduler.sv
// Batch sequencer: launches NUM_CHALLENGES consecutive PUF evaluations and packs the response bits.
module puf_challenge_scheduler
    import puf_pkg::*;
#(
    parameter int CHALLENGE_BITS = 4,
    parameter int NUM_CHALLENGES = 8,
    parameter int TIMEOUT_BITS   = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [CHALLENGE_BITS-1:0] base_challenge,
    output logic                      fsm_start,
    output logic [CHALLENGE_BITS-1:0] fsm_challenge,
    input  logic                      fsm_done,
    input  logic                      puf_response,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [NUM_CHALLENGES-1:0] resp_data,
    output logic                      resp_error
);

    localparam int IDX_W = idx_bits(NUM_CHALLENGES);

    sched_state_t              state;
    logic [CHALLENGE_BITS-1:0] base_q;
    logic [IDX_W-1:0]          idx;
    logic                      done_q;
    logic                      rise;
    logic                      last;
    logic                      accept;
    logic                      wd_clear;
    logic                      wd_enable;
    logic                      wd_expired;

    assign req_ready     = (state == IDLE) && !reset;
    assign accept        = req_valid && req_ready;
    assign rise          = fsm_done && !done_q;
    assign last          = (idx == IDX_W'(NUM_CHALLENGES - 1));
    assign wd_clear      = accept || (state == LAUNCH);
    assign wd_enable     = (state == WAIT);
    assign fsm_start     = (state == LAUNCH);
    assign resp_valid    = (state == OUTPUT);
    assign fsm_challenge = ((state == LAUNCH) || (state == WAIT))
                         ? base_q + CHALLENGE_BITS'(idx) : '0;

    puf_watchdog #(
        .TIMEOUT_BITS  (TIMEOUT_BITS),
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk    (clk),
        .reset  (reset),
        .clear  (wd_clear),
        .enable (wd_enable),
        .expired(wd_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            base_q     <= '0;
            idx        <= '0;
            done_q     <= 1'b0;
            resp_data  <= '0;
            resp_error <= 1'b0;
        end else begin
            done_q <= fsm_done;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        base_q     <= base_challenge;
                        idx        <= '0;
                        resp_data  <= '0;
                        resp_error <= 1'b0;
                        state      <= LAUNCH;
                    end
                end
                LAUNCH: state <= WAIT;
                WAIT: begin
                    // A done edge coinciding with expiry still counts as a valid capture.
                    if (rise || wd_expired) begin
                        resp_data[idx] <= rise && puf_response;
                        if (!rise) begin
                            resp_error <= 1'b1;
                        end
                        if (last) begin
                            state <= OUTPUT;
                        end else begin
                            idx   <= idx + IDX_W'(1);
                            state <= LAUNCH;
                        end
                    end
                end
                OUTPUT: begin
                    if (resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_puf_challenge_scheduler.sv
// Self-checking bench: directed and randomized batches against a responder model and expected-word model.
module tb_puf_challenge_scheduler;

    localparam int CB    = 4;
    localparam int NC    = 4;
    localparam int TO    = 64;
    localparam int STUCK = 255;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_valid;
    logic          req_ready;
    logic [CB-1:0] base_challenge;
    logic          fsm_start;
    logic [CB-1:0] fsm_challenge;
    logic          fsm_done;
    logic          puf_response;
    logic          resp_valid;
    logic          resp_ready;
    logic [NC-1:0] resp_data;
    logic          resp_error;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    int dly [NC];
    int model_idx;

    puf_challenge_scheduler #(
        .CHALLENGE_BITS(CB),
        .NUM_CHALLENGES(NC),
        .TIMEOUT_BITS  (16),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .base_challenge(base_challenge),
        .fsm_start     (fsm_start),
        .fsm_challenge (fsm_challenge),
        .fsm_done      (fsm_done),
        .puf_response  (puf_response),
        .resp_valid    (resp_valid),
        .resp_ready    (resp_ready),
        .resp_data     (resp_data),
        .resp_error    (resp_error)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not complete in time");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [CB-1:0] ch(input logic [CB-1:0] b, input int k);
        logic [CB-1:0] kk;
        kk = k[CB-1:0];
        return b + kk;
    endfunction

    // An evaluation is captured when the fresh done edge lands within the TO WAIT cycles.
    function automatic bit captured(input int d);
        return (d >= 1) && (d <= TO);
    endfunction

    function automatic int gap(input int d);
        return captured(d) ? d + 1 : TO + 1;
    endfunction

    function automatic logic [NC-1:0] exp_data(input logic [CB-1:0] b);
        logic [NC-1:0] r;
        r = '0;
        for (int i = 0; i < NC; i++)
            if (captured(dly[i])) r[i] = ^ch(b, i);
        return r;
    endfunction

    function automatic logic exp_err();
        logic e;
        e = 1'b0;
        for (int i = 0; i < NC; i++)
            if (!captured(dly[i])) e = 1'b1;
        return e;
    endfunction

    // PUF responder: dly[k] = cycles from start to done rise; 0 = silent; STUCK = keep done level.
    initial begin
        int cnt;
        int cur;
        logic [CB-1:0] chal;
        fsm_done     = 1'b0;
        puf_response = 1'b0;
        cnt          = -1;
        cur          = 0;
        chal         = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                cnt          = -1;
                fsm_done     = 1'b0;
                puf_response = 1'b0;
            end else if (fsm_start) begin
                cur  = (model_idx < NC) ? dly[model_idx] : 10;
                chal = fsm_challenge;
                model_idx++;
                cnt  = 0;
                if (cur == STUCK) begin
                    puf_response = 1'b1;
                end else begin
                    fsm_done     = 1'b0;
                    puf_response = 1'b0;
                end
            end else if (cnt >= 0) begin
                cnt++;
                if (cur != 0 && cur != STUCK && cnt == cur) begin
                    fsm_done     = 1'b1;
                    puf_response = ^chal;
                end
            end
        end
    end

    task automatic run_batch(input logic [CB-1:0] base, input int bp);
        int prev_cyc;
        int budget;
        logic [NC-1:0] ed;
        logic          ee;
        ed = exp_data(base);
        ee = exp_err();
        model_idx      = 0;
        req_valid      = 1'b1;
        base_challenge = base;
        check("req_ready_idle", req_ready, 1);
        step();
        req_valid      = 1'b0;
        base_challenge = CB'($urandom);
        check("start_after_accept", fsm_start, 1);
        prev_cyc = cyc;
        for (int k = 0; k < NC; k++) begin
            budget = 0;
            while (!fsm_start && budget < 200) begin
                check("chal_hold", fsm_challenge, ch(base, k - 1));
                step();
                budget++;
            end
            if (!fsm_start) begin
                check("start_seen", 0, 1);
                return;
            end
            check("chal", fsm_challenge, ch(base, k));
            if (k > 0) check("start_gap", cyc - prev_cyc, gap(dly[k - 1]));
            prev_cyc = cyc;
            step();
        end
        budget = 0;
        while (!resp_valid && budget < 200) begin
            check("chal_hold_last", fsm_challenge, ch(base, NC - 1));
            step();
            budget++;
        end
        check("resp_valid_gap", cyc - prev_cyc, gap(dly[NC - 1]));
        check("resp_data", resp_data, ed);
        check("resp_error", resp_error, ee);
        check("chal_output_zero", fsm_challenge, 0);
        check("req_ready_output", req_ready, 0);
        for (int b = 0; b < bp; b++) begin
            req_valid      = 1'b1;
            base_challenge = CB'($urandom);
            step();
            check("bp_valid", resp_valid, 1);
            check("bp_data", resp_data, ed);
            check("bp_error", resp_error, ee);
            check("bp_req_ready", req_ready, 0);
            check("bp_no_start", fsm_start, 0);
        end
        req_valid  = 1'b0;
        resp_ready = 1'b1;
        step();
        resp_ready = 1'b0;
        check("ready_after_hs", req_ready, 1);
        check("valid_after_hs", resp_valid, 0);
        check("data_held_idle", resp_data, ed);
        check("error_held_idle", resp_error, ee);
        check("no_start_idle", fsm_start, 0);
    endtask

    initial begin
        logic [CB-1:0] rb;
        reset          = 1'b1;
        req_valid      = 1'b0;
        resp_ready     = 1'b0;
        base_challenge = '0;
        model_idx      = 0;
        for (int i = 0; i < NC; i++) dly[i] = 10;
        step();
        step();
        check("rst_req_ready", req_ready, 0);
        check("rst_start", fsm_start, 0);
        check("rst_valid", resp_valid, 0);
        check("rst_data", resp_data, 0);
        check("rst_error", resp_error, 0);
        check("rst_chal", fsm_challenge, 0);
        reset = 1'b0;
        #1;
        check("ready_after_reset", req_ready, 1);
        step();

        // Nominal and wrap-around.
        run_batch(4'h3, 0);
        run_batch(4'hE, 2);

        // Silent PUF on idx 2.
        dly = '{10, 10, 0, 10};
        run_batch(4'h3, 0);

        // done held high across idx 1.
        dly = '{10, STUCK, 10, 10};
        run_batch(4'h3, 1);

        // Edge on the watchdog's final cycle.
        dly = '{10, TO, 10, 10};
        run_batch(4'h3, 0);

        // Backpressure with concurrent requests.
        dly = '{10, 10, 10, 10};
        run_batch(4'h5, 20);

        // Reset mid-WAIT at idx 1.
        model_idx      = 0;
        req_valid      = 1'b1;
        base_challenge = 4'h3;
        step();
        req_valid = 1'b0;
        for (int i = 0; i < 30 && !(fsm_start && model_idx >= 1); i++) step();
        step();
        step();
        step();
        reset = 1'b1;
        step();
        check("mid_rst_start", fsm_start, 0);
        check("mid_rst_valid", resp_valid, 0);
        check("mid_rst_data", resp_data, 0);
        check("mid_rst_error", resp_error, 0);
        check("mid_rst_chal", fsm_challenge, 0);
        check("mid_rst_ready", req_ready, 0);
        reset = 1'b0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (resp_valid || fsm_start) check("post_rst_quiet", {resp_valid, fsm_start}, 0);
        end
        check("post_rst_ready", req_ready, 1);
        run_batch(4'h0, 0);
        check("base0_word", resp_data, 4'b0110);

        // Randomized batches.
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < NC; i++) begin
                case ($urandom_range(0, 5))
                    0:       dly[i] = 0;
                    1:       dly[i] = STUCK;
                    2:       dly[i] = TO;
                    3:       dly[i] = $urandom_range(TO + 1, TO + 30);
                    default: dly[i] = $urandom_range(1, TO - 1);
                endcase
            end
            rb = CB'($urandom);
            run_batch(rb, $urandom_range(0, 5));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/puf_challenge_scheduler.md
# puf_challenge_scheduler

Batch sequencer between the host request interface and the PUF `StateMachine` controller. Accepts one base challenge, runs `NUM_CHALLENGES` consecutive evaluations (base, base+1, … modulo 2^`CHALLENGE_BITS`) by pulsing `StateMachine.start`, and captures one response bit per evaluation. It returns the packed response word over a valid/ready handshake. A per-evaluation watchdog ensures a stalled PUF cannot hang the batch.

## Interface
Parameters:
- `CHALLENGE_BITS`, 4, width of the challenge driven to `StateMachine`
- `NUM_CHALLENGES`, 8, evaluations per batch and width of `resp_data` (≥1)
- `TIMEOUT_BITS`, 16, width of the watchdog counter
- `TIMEOUT_CYCLES`, 1024, maximum WAIT cycles per evaluation (≥2, < 2^`TIMEOUT_BITS`)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `req_valid`  in  1  batch request
- `req_ready`  out  1  scheduler can accept a request
- `base_challenge`  in  `CHALLENGE_BITS`  first challenge, sampled on request accept
- `fsm_start`  out  1  one-cycle start pulse to `StateMachine`
- `fsm_challenge`  out  `CHALLENGE_BITS`  challenge for the current evaluation
- `fsm_done`  in  1  `StateMachine.done` (level)
- `puf_response`  in  1  response bit, valid while `fsm_done` is high
- `resp_valid`  out  1  response word available
- `resp_ready`  in  1  consumer accepts word
- `resp_data`  out  `NUM_CHALLENGES`  bit i = response to challenge base+i
- `resp_error`  out  1  at least one evaluation in the batch timed out

## Operation
- States: IDLE, LAUNCH, WAIT, OUTPUT.
- IDLE: `req_ready`=1. On `req_valid`: latch base, clear idx, shift register, error flag, and watchdog, then go to LAUNCH.
- LAUNCH: `fsm_start`=1 for exactly this cycle. Clear the watchdog and go to WAIT.
- `fsm_challenge` = (base + idx) mod 2^`CHALLENGE_BITS`. It is held stable from LAUNCH through the end of WAIT. It is 0 in IDLE and OUTPUT.
- WAIT: watchdog increments each cycle. The evaluation completes on either of two conditions:
  - Done: a rising edge of `fsm_done` (`fsm_done`=1 and the registered previous value `done_q`=0). Write `puf_response` into `resp_data[idx]`.
  - Timeout: watchdog = `TIMEOUT_CYCLES`-1 with no edge. Write 0 into `resp_data[idx]` and set the sticky error flag.
- Edge and timeout in the same cycle: the edge wins and no error is raised.
- After completion: if idx = `NUM_CHALLENGES`-1, go to OUTPUT; otherwise increment idx and go to LAUNCH.
- `fsm_done` that is already high when WAIT is entered is not an edge. The evaluation waits for a fresh rising edge or times out.
- OUTPUT: `resp_valid`=1. `resp_data` and `resp_error` are held stable until `resp_ready`, then go to IDLE. `req_valid` is ignored outside IDLE.
- `resp_data` and `resp_error` hold their last values in IDLE. They are cleared on the next request accept.

## Timing
- Reset values: `req_ready`=0 during reset and 1 on the first cycle after reset deasserts (IDLE). All other outputs are 0. State is IDLE, idx and watchdog are 0, `done_q`=0.
- Reset asserted in any state, including mid-WAIT: return to IDLE on the next edge. `fsm_start` must not pulse. The partial batch is discarded and `resp_valid` is never raised for it.
- Request accepted at cycle T: `fsm_start` is high at T+1.
- Completion detected at cycle D: the next `fsm_start` is at D+1. For the final evaluation, `resp_valid` is high from D+1.
- Timed-out evaluation: exactly `TIMEOUT_CYCLES` WAIT cycles, with the next `fsm_start` `TIMEOUT_CYCLES`+1 cycles after the previous one.
- Handshake on `resp_valid` & `resp_ready` at cycle H: `req_ready`=1 at H+1. Minimum batch-to-batch gap is one IDLE cycle.
- Watchdog width: saturation never occurs because of the `TIMEOUT_CYCLES` bound. idx width is $clog2(`NUM_CHALLENGES`), minimum 1.

## Structure
- `puf_pkg`: state enum `sched_state_t` (IDLE, LAUNCH, WAIT, OUTPUT). Shared with future PUF controllers.
- One sub-module, `puf_watchdog`: clear, enable, and `expired` output at count `TIMEOUT_CYCLES`-1, parameterised by `TIMEOUT_BITS`/`TIMEOUT_CYCLES`.
- The edge detector, shift register, and index counter stay inline.

## Test plan
Parameters: `NUM_CHALLENGES`=4, `CHALLENGE_BITS`=4, `TIMEOUT_CYCLES`=64. The bench model raises `fsm_done` 10 cycles after `fsm_start`, drops it on the next start, and returns response = parity(challenge).
- Nominal: base=4'h3 → challenges 3,4,5,6 in order, `resp_data`=4'b0010, `resp_error`=0, `fsm_start` spacing 11 cycles.
- Wrap-around: base=4'hE → challenges E,F,0,1, `resp_data`=4'b1001.
- Timeout: model silent for idx 2, base=4'h3 → idx 2 slot lasts exactly 64 WAIT cycles, `resp_data`=4'b0010, `resp_error`=1.
- Stuck-high done: `fsm_done` held 1 across idx 1 → no edge, timeout, `resp_data[1]`=0, `resp_error`=1. Edge exactly on the watchdog's last cycle → bit captured, `resp_error`=0.
- Backpressure: `resp_ready` low for 20 cycles → `resp_valid`, `resp_data`, and `resp_error` stable; `req_ready`=0; a concurrent `req_valid` is not accepted. `req_ready`=1 one cycle after the handshake.
- Reset mid-WAIT at idx 1 → all outputs 0 on the next cycle, no `resp_valid`. A new request with base=4'h0 then completes normally with `resp_data`=4'b0110.
